mcu_ctrl: RTL and testbench
===========================

MCU_CTRL -- requirements
Module: mcu_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_LIMIT, default 8'd255, the maximum number of cycles spent in any memory-wait state before a bus-error halt.
REQ-002 The block SHALL have these ports:
- MCU_CTRL_CLOCK_50  input  1  sole clock, rising edge.
- MCU_CTRL_RESET_InHigh  input  1  reset, synchronous and active-high.
- MCU_CTRL_Opcode_InBUS  input  7  opcode field of the instruction register.
- MCU_CTRL_Ifu_Valid  input  1  fetch data valid.
- MCU_CTRL_Lsu_Ready  input  1  LSU accepts a request.
- MCU_CTRL_Lsu_Valid  input  1  LSU response valid.
- MCU_CTRL_Halt_In  input  1  external halt request.
- MCU_CTRL_State_OutBUS  output  3  current state; drives IDU_Mcu_State.
- MCU_CTRL_Ifu_Req  output  1  fetch request.
- MCU_CTRL_Ir_Write  output  1  instruction-register load strobe.
- MCU_CTRL_Pc_Write  output  1  PC update strobe (instruction retire).
- MCU_CTRL_Lsu_Req_Valid  output  1  LSU request valid.
- MCU_CTRL_Halted  output  1  in HALT state.
- MCU_CTRL_Err_OutBUS  output  2  halt cause: 00 none, 01 external, 10 illegal opcode, 11 bus timeout.
- MCU_CTRL_Retired_OutBUS  output  32  retired-instruction count.

Function
REQ-003 State encoding SHALL be: RESET 000, FETCH 001, DECODE 010, EXEC 011, MEM_REQ 100, MEM_WAIT 101, HALT 110; code 111 SHALL transition to HALT with Err 11.
REQ-004 State, Err, Retired and the wait counter SHALL be registered; State_OutBUS SHALL equal the state register.
REQ-005 RESET SHALL go to FETCH on the next cycle unconditionally.
REQ-006 FETCH SHALL drive Ifu_Req=1.
- If Halt_In=1: go to HALT with Err=01 (Halt_In takes priority over Ifu_Valid).
- Else if Ifu_Valid=1: drive Ir_Write=1 for that cycle and go to DECODE.
- Else: stay in FETCH.
REQ-007 DECODE SHALL go to EXEC when Opcode is one of 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011.
- Otherwise: go to HALT with Err=10.
REQ-008 EXEC lasts exactly one cycle.
- Opcode matches 0?00011 (load or store): go to MEM_REQ with Pc_Write=0.
- Otherwise: drive Pc_Write=1 and go to FETCH.
REQ-009 MEM_REQ SHALL drive Lsu_Req_Valid=1 until the cycle in which Lsu_Ready=1, then go to MEM_WAIT; Lsu_Req_Valid SHALL be 0 in every other state.
REQ-010 MEM_WAIT SHALL, in the cycle Lsu_Valid=1, drive Pc_Write=1 and go to FETCH.
- Lsu_Valid=1 in MEM_REQ SHALL be ignored.
REQ-011 A wait counter SHALL clear on entry to MEM_REQ and on entry to MEM_WAIT, and increment each cycle spent in either state.
- When it reaches WAIT_LIMIT without the exit condition: go to HALT with Err=11.
- An exit condition in the same cycle as the limit SHALL win.
REQ-012 Ifu_Req, Ir_Write, Pc_Write and Lsu_Req_Valid SHALL be combinational functions of the state and inputs (Mealy), and SHALL be 0 in RESET, DECODE, HALT and 111.
REQ-013 Retired SHALL increment by 1 on every cycle Pc_Write=1, and wrap from FFFFFFFF to 00000000.
REQ-014 HALT SHALL be absorbing: Halted=1, all strobes 0, Err held; exit only via reset.
REQ-015 Err SHALL be written only on entry to HALT.
REQ-016 Exactly one of Ifu_Req, Pc_Write, Lsu_Req_Valid SHALL be asserted per cycle at most, except that Ifu_Req and Ir_Write coincide in FETCH.

Reset
REQ-017 With RESET_InHigh=1 at a rising edge, the next state SHALL be:
- State=000; Err=00; Retired=0; wait counter=0.
- All strobes=0; Halted=0.
REQ-018 Reset SHALL override every transition, including mid-MEM_WAIT and HALT.
- Outstanding LSU transactions SHALL be abandoned without handshake.

Verification
REQ-019 ADDI flow: Opcode=0010011, Ifu_Valid=1 in FETCH -> states 001,010,011,001; Pc_Write pulse in EXEC; Retired=1.
REQ-020 Load with backpressure: Opcode=0000011, Lsu_Ready low 3 cycles, Lsu_Valid 2 cycles after accept -> Lsu_Req_Valid high 4 cycles; State 100 then 101; one Pc_Write; Retired +1.
REQ-021 Illegal opcode 1111111 in DECODE -> State=110, Err=10, Halted=1; Ifu_Valid pulses afterwards cause no change.
REQ-022 Timeout: WAIT_LIMIT=4, store; Lsu_Ready=1; Lsu_Valid never -> HALT with Err=11 after 4 cycles in MEM_WAIT.
REQ-023 Halt_In=1 together with Ifu_Valid=1 in FETCH -> HALT, Err=01, Ir_Write=0.
REQ-024 Reset asserted in MEM_WAIT -> State=000 next cycle, then 001; Retired preloaded near FFFFFFFF to FFFFFFFF before reset -> wrap check: after one retire Retired=0, then reset clears.

Source files
------------

// File: rtl/mcu_ctrl.sv
// Multi-cycle MCU sequencer: fetch/decode/execute with LSU handshake,
// bus-wait timeout, halt-cause capture and retired-instruction counter.
module mcu_ctrl #(
    parameter logic [7:0] WAIT_LIMIT = 8'd255
) (
    input  logic        MCU_CTRL_CLOCK_50,
    input  logic        MCU_CTRL_RESET_InHigh,
    input  logic [6:0]  MCU_CTRL_Opcode_InBUS,
    input  logic        MCU_CTRL_Ifu_Valid,
    input  logic        MCU_CTRL_Lsu_Ready,
    input  logic        MCU_CTRL_Lsu_Valid,
    input  logic        MCU_CTRL_Halt_In,
    output logic [2:0]  MCU_CTRL_State_OutBUS,
    output logic        MCU_CTRL_Ifu_Req,
    output logic        MCU_CTRL_Ir_Write,
    output logic        MCU_CTRL_Pc_Write,
    output logic        MCU_CTRL_Lsu_Req_Valid,
    output logic        MCU_CTRL_Halted,
    output logic [1:0]  MCU_CTRL_Err_OutBUS,
    output logic [31:0] MCU_CTRL_Retired_OutBUS
);

    // state    | meaning
    // RESET    | first cycle after reset
    // FETCH    | request instruction, load IR on fetch valid
    // DECODE   | check opcode legality
    // EXEC     | retire ALU/branch ops, route loads/stores to memory
    // MEM_REQ  | hold LSU request until accepted
    // MEM_WAIT | wait for LSU response
    // HALT     | absorbing until reset, cause in Err
    // BAD      | unreachable code, forced to HALT with bus-error cause
    typedef enum logic [2:0] {
        ST_RESET    = 3'b000,
        ST_FETCH    = 3'b001,
        ST_DECODE   = 3'b010,
        ST_EXEC     = 3'b011,
        ST_MEM_REQ  = 3'b100,
        ST_MEM_WAIT = 3'b101,
        ST_HALT     = 3'b110,
        ST_BAD      = 3'b111
    } state_t;

    localparam logic [1:0] ERR_EXT  = 2'b01;
    localparam logic [1:0] ERR_ILL  = 2'b10;
    localparam logic [1:0] ERR_BUS  = 2'b11;

    state_t      state_q, state_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] retired_q, retired_d;
    logic [7:0]  wait_q, wait_d;

    logic op_legal, op_ldst, wait_at_limit;
    logic ifu_req, ir_write, pc_write, lsu_req_valid;

    assign op_ldst = (MCU_CTRL_Opcode_InBUS[6] == 1'b0) &&
                     (MCU_CTRL_Opcode_InBUS[4:0] == 5'b00011);
    assign op_legal = MCU_CTRL_Opcode_InBUS inside {
        7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
        7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    // wait_q counts completed cycles, so this is the last permitted cycle
    assign wait_at_limit = (wait_q == WAIT_LIMIT - 8'd1);

    always_comb begin
        state_d       = state_q;
        err_d         = err_q;
        wait_d        = wait_q;
        ifu_req       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        lsu_req_valid = 1'b0;
        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                ifu_req = 1'b1;
                if (MCU_CTRL_Halt_In) begin
                    state_d = ST_HALT;
                    err_d   = ERR_EXT;
                end else if (MCU_CTRL_Ifu_Valid) begin
                    ir_write = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (op_legal) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_HALT;
                    err_d   = ERR_ILL;
                end
            end
            ST_EXEC: begin
                if (op_ldst) begin
                    state_d = ST_MEM_REQ;
                    wait_d  = 8'd0;
                end else begin
                    pc_write = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            ST_MEM_REQ: begin
                lsu_req_valid = 1'b1;
                if (MCU_CTRL_Lsu_Ready) begin
                    state_d = ST_MEM_WAIT;
                    wait_d  = 8'd0;
                end else if (wait_at_limit) begin
                    state_d = ST_HALT;
                    err_d   = ERR_BUS;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_MEM_WAIT: begin
                if (MCU_CTRL_Lsu_Valid) begin
                    pc_write = 1'b1;
                    state_d  = ST_FETCH;
                end else if (wait_at_limit) begin
                    state_d = ST_HALT;
                    err_d   = ERR_BUS;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: begin
                state_d = ST_HALT;
                err_d   = ERR_BUS;
            end
        endcase
    end

    assign retired_d = pc_write ? retired_q + 32'd1 : retired_q;

    always_ff @(posedge MCU_CTRL_CLOCK_50) begin
        if (MCU_CTRL_RESET_InHigh) begin
            state_q   <= ST_RESET;
            err_q     <= 2'b00;
            retired_q <= 32'd0;
            wait_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            retired_q <= retired_d;
            wait_q    <= wait_d;
        end
    end

    assign MCU_CTRL_State_OutBUS   = state_q;
    assign MCU_CTRL_Ifu_Req        = ifu_req;
    assign MCU_CTRL_Ir_Write       = ir_write;
    assign MCU_CTRL_Pc_Write       = pc_write;
    assign MCU_CTRL_Lsu_Req_Valid  = lsu_req_valid;
    assign MCU_CTRL_Halted         = (state_q == ST_HALT);
    assign MCU_CTRL_Err_OutBUS     = err_q;
    assign MCU_CTRL_Retired_OutBUS = retired_q;

endmodule

// File: tb/tb_mcu_ctrl.sv
// Bench for mcu_ctrl: directed vector table, hand-written corner sequences,
// then randomized stimulus against a phase-level reference model.
module tb_mcu_ctrl;
    localparam logic [7:0] WL = 8'd4;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst, iv, lr, lv, hi;
    logic [6:0]  op;
    logic [2:0]  st;
    logic        ifu, ir, pc, lsu, hlt;
    logic [1:0]  err;
    logic [31:0] ret;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mcu_ctrl #(.WAIT_LIMIT(WL)) dut (
        .MCU_CTRL_CLOCK_50      (clk),
        .MCU_CTRL_RESET_InHigh  (rst),
        .MCU_CTRL_Opcode_InBUS  (op),
        .MCU_CTRL_Ifu_Valid     (iv),
        .MCU_CTRL_Lsu_Ready     (lr),
        .MCU_CTRL_Lsu_Valid     (lv),
        .MCU_CTRL_Halt_In       (hi),
        .MCU_CTRL_State_OutBUS  (st),
        .MCU_CTRL_Ifu_Req       (ifu),
        .MCU_CTRL_Ir_Write      (ir),
        .MCU_CTRL_Pc_Write      (pc),
        .MCU_CTRL_Lsu_Req_Valid (lsu),
        .MCU_CTRL_Halted        (hlt),
        .MCU_CTRL_Err_OutBUS    (err),
        .MCU_CTRL_Retired_OutBUS(ret)
    );

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        iv, lr, lv, hi;
        logic [10:0] eo;
        logic [31:0] er;
    } vec_t;

    vec_t tv[$];

    // expected output bundle {state, ifu, ir, pc, lsu, halted, err}
    function automatic logic [10:0] o(input logic [2:0] s, input logic f, input logic i,
                                      input logic p, input logic l, input logic [1:0] e);
        return {s, f, i, p, l, (s == 3'b110), e};
    endfunction

    function automatic vec_t mk(input logic r, input logic [6:0] opc, input logic a,
                                input logic b, input logic c, input logic d,
                                input logic [10:0] eo, input logic [31:0] er);
        vec_t v;
        v.rst = r; v.op = opc; v.iv = a; v.lr = b; v.lv = c; v.hi = d;
        v.eo = eo; v.er = er;
        return v;
    endfunction

    task automatic apply(input logic r, input logic [6:0] opc, input logic a, input logic b,
                         input logic c, input logic d, input logic [10:0] eo,
                         input logic [31:0] er, input string nm);
        @(negedge clk);
        rst = r; op = opc; iv = a; lr = b; lv = c; hi = d;
        #1;
        n_vec++;
        if ({st, ifu, ir, pc, lsu, hlt, err} !== eo || ret !== er) begin
            n_bad++;
            $display("FAIL %s: got st=%b ifu=%b ir=%b pc=%b lsu=%b halted=%b err=%b ret=%h; want outs=%b ret=%h",
                     nm, st, ifu, ir, pc, lsu, hlt, err, ret, eo, er);
        end
    endtask

    // ---- reference model, tracked as abstract phases ----
    typedef enum {M_RESET, M_FETCH, M_DECODE, M_EXEC, M_MREQ, M_MWAIT, M_HALT} mph_t;
    mph_t       m_ph;
    int         m_dwell;
    logic [1:0] m_err;
    longint     m_ret;
    logic [6:0] legal_ops [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                  7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                                  7'b0110011};

    function automatic logic [2:0] code(input mph_t p);
        case (p)
            M_RESET:  return 3'd0;
            M_FETCH:  return 3'd1;
            M_DECODE: return 3'd2;
            M_EXEC:   return 3'd3;
            M_MREQ:   return 3'd4;
            M_MWAIT:  return 3'd5;
            default:  return 3'd6;
        endcase
    endfunction

    function automatic bit is_legal(input logic [6:0] opc);
        foreach (legal_ops[k]) if (legal_ops[k] == opc) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input logic r, input logic [6:0] opc, input logic a,
                              input logic b, input logic c, input logic d,
                              output logic [10:0] eo, output logic [31:0] er);
        logic f = 0, i = 0, p = 0, l = 0;
        mph_t nx = m_ph;
        logic [1:0] ne = m_err;
        int nd = m_dwell;
        case (m_ph)
            M_RESET: nx = M_FETCH;
            M_FETCH: begin
                f = 1;
                if (d) begin nx = M_HALT; ne = 2'd1; end
                else if (a) begin i = 1; nx = M_DECODE; end
            end
            M_DECODE: if (is_legal(opc)) nx = M_EXEC; else begin nx = M_HALT; ne = 2'd2; end
            M_EXEC: begin
                if (opc == OP_LD || opc == OP_ST) begin nx = M_MREQ; nd = 0; end
                else begin p = 1; nx = M_FETCH; end
            end
            M_MREQ: begin
                l = 1;
                if (b) begin nx = M_MWAIT; nd = 0; end
                else if (m_dwell + 1 >= int'(WL)) begin nx = M_HALT; ne = 2'd3; end
                else nd = m_dwell + 1;
            end
            M_MWAIT: begin
                if (c) begin p = 1; nx = M_FETCH; end
                else if (m_dwell + 1 >= int'(WL)) begin nx = M_HALT; ne = 2'd3; end
                else nd = m_dwell + 1;
            end
            default: nx = M_HALT;
        endcase
        eo = {code(m_ph), f, i, p, l, (m_ph == M_HALT), m_err};
        er = m_ret[31:0];
        if (r) begin
            m_ph = M_RESET; m_err = 2'd0; m_ret = 0; m_dwell = 0;
        end else begin
            m_ph = nx; m_err = ne; m_dwell = nd;
            m_ret = (m_ret + longint'(p)) % 64'h1_0000_0000;
        end
    endtask

    logic        r_r, r_iv, r_lr, r_lv, r_hi;
    logic [6:0]  r_op;
    logic [10:0] r_eo;
    logic [31:0] r_er;

    initial begin
        rst = 1'b1; op = 7'd0; iv = 1'b0; lr = 1'b0; lv = 1'b0; hi = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // ADDI flow
        tv.push_back(mk(0, OP_ADDI, 0, 0, 0, 0, o(3'd0, 0, 0, 0, 0, 2'd0), 0));
        tv.push_back(mk(0, OP_ADDI, 1, 0, 0, 0, o(3'd1, 1, 1, 0, 0, 2'd0), 0));
        tv.push_back(mk(0, OP_ADDI, 0, 0, 0, 0, o(3'd2, 0, 0, 0, 0, 2'd0), 0));
        tv.push_back(mk(0, OP_ADDI, 0, 0, 0, 0, o(3'd3, 0, 0, 1, 0, 2'd0), 0));
        // load with 3 cycles of backpressure, accept on the limit cycle
        tv.push_back(mk(0, OP_LD, 0, 0, 0, 0, o(3'd1, 1, 0, 0, 0, 2'd0), 1));
        tv.push_back(mk(0, OP_LD, 1, 0, 0, 0, o(3'd1, 1, 1, 0, 0, 2'd0), 1));
        tv.push_back(mk(0, OP_LD, 0, 0, 0, 0, o(3'd2, 0, 0, 0, 0, 2'd0), 1));
        tv.push_back(mk(0, OP_LD, 0, 0, 0, 0, o(3'd3, 0, 0, 0, 0, 2'd0), 1));
        tv.push_back(mk(0, OP_LD, 0, 0, 0, 0, o(3'd4, 0, 0, 0, 1, 2'd0), 1));
        tv.push_back(mk(0, OP_LD, 0, 0, 1, 0, o(3'd4, 0, 0, 0, 1, 2'd0), 1));
        tv.push_back(mk(0, OP_LD, 0, 0, 0, 0, o(3'd4, 0, 0, 0, 1, 2'd0), 1));
        tv.push_back(mk(0, OP_LD, 0, 1, 0, 0, o(3'd4, 0, 0, 0, 1, 2'd0), 1));
        tv.push_back(mk(0, OP_LD, 0, 0, 0, 0, o(3'd5, 0, 0, 0, 0, 2'd0), 1));
        tv.push_back(mk(0, OP_LD, 0, 0, 1, 0, o(3'd5, 0, 0, 1, 0, 2'd0), 1));
        tv.push_back(mk(0, OP_LD, 0, 0, 0, 0, o(3'd1, 1, 0, 0, 0, 2'd0), 2));
        // external halt beats fetch valid
        tv.push_back(mk(0, OP_ADDI, 1, 0, 0, 1, o(3'd1, 1, 0, 0, 0, 2'd0), 2));
        tv.push_back(mk(0, OP_ADDI, 1, 0, 0, 0, o(3'd6, 0, 0, 0, 0, 2'd1), 2));
        tv.push_back(mk(0, OP_ADDI, 1, 1, 1, 1, o(3'd6, 0, 0, 0, 0, 2'd1), 2));
        tv.push_back(mk(1, OP_ADDI, 0, 0, 0, 0, o(3'd6, 0, 0, 0, 0, 2'd1), 2));
        // illegal opcode
        tv.push_back(mk(0, OP_BAD, 0, 0, 0, 0, o(3'd0, 0, 0, 0, 0, 2'd0), 0));
        tv.push_back(mk(0, OP_BAD, 1, 0, 0, 0, o(3'd1, 1, 1, 0, 0, 2'd0), 0));
        tv.push_back(mk(0, OP_BAD, 0, 0, 0, 0, o(3'd2, 0, 0, 0, 0, 2'd0), 0));
        tv.push_back(mk(0, OP_BAD, 1, 0, 0, 0, o(3'd6, 0, 0, 0, 0, 2'd2), 0));
        tv.push_back(mk(0, OP_ADDI, 1, 0, 0, 0, o(3'd6, 0, 0, 0, 0, 2'd2), 0));
        tv.push_back(mk(1, OP_ADDI, 0, 0, 0, 0, o(3'd6, 0, 0, 0, 0, 2'd2), 0));
        // JAL retires from EXEC
        tv.push_back(mk(0, OP_JAL, 0, 0, 0, 0, o(3'd0, 0, 0, 0, 0, 2'd0), 0));
        tv.push_back(mk(0, OP_JAL, 1, 0, 0, 0, o(3'd1, 1, 1, 0, 0, 2'd0), 0));
        tv.push_back(mk(0, OP_JAL, 0, 0, 0, 0, o(3'd2, 0, 0, 0, 0, 2'd0), 0));
        tv.push_back(mk(0, OP_JAL, 0, 0, 0, 0, o(3'd3, 0, 0, 1, 0, 2'd0), 0));
        // store that never gets accepted: MEM_REQ timeout
        tv.push_back(mk(0, OP_ST, 1, 0, 0, 0, o(3'd1, 1, 1, 0, 0, 2'd0), 1));
        tv.push_back(mk(0, OP_ST, 0, 0, 0, 0, o(3'd2, 0, 0, 0, 0, 2'd0), 1));
        tv.push_back(mk(0, OP_ST, 0, 0, 0, 0, o(3'd3, 0, 0, 0, 0, 2'd0), 1));
        for (int k = 0; k < 4; k++)
            tv.push_back(mk(0, OP_ST, 0, 0, 0, 0, o(3'd4, 0, 0, 0, 1, 2'd0), 1));
        tv.push_back(mk(0, OP_ST, 0, 0, 0, 0, o(3'd6, 0, 0, 0, 0, 2'd3), 1));

        foreach (tv[k])
            apply(tv[k].rst, tv[k].op, tv[k].iv, tv[k].lr, tv[k].lv, tv[k].hi,
                  tv[k].eo, tv[k].er, $sformatf("table[%0d]", k));

        // store accepted, response never arrives: MEM_WAIT timeout after 4 cycles
        apply(1, OP_ST, 0, 0, 0, 0, o(3'd6, 0, 0, 0, 0, 2'd3), 1, "to_rst");
        apply(0, OP_ST, 0, 0, 0, 0, o(3'd0, 0, 0, 0, 0, 2'd0), 0, "to_reset");
        apply(0, OP_ST, 1, 0, 0, 0, o(3'd1, 1, 1, 0, 0, 2'd0), 0, "to_fetch");
        apply(0, OP_ST, 0, 0, 0, 0, o(3'd2, 0, 0, 0, 0, 2'd0), 0, "to_decode");
        apply(0, OP_ST, 0, 0, 0, 0, o(3'd3, 0, 0, 0, 0, 2'd0), 0, "to_exec");
        apply(0, OP_ST, 0, 1, 0, 0, o(3'd4, 0, 0, 0, 1, 2'd0), 0, "to_memreq");
        for (int k = 0; k < 4; k++)
            apply(0, OP_ST, 0, 1, 0, 0, o(3'd5, 0, 0, 0, 0, 2'd0), 0, "to_memwait");
        apply(0, OP_ST, 0, 1, 0, 0, o(3'd6, 0, 0, 0, 0, 2'd3), 0, "to_halt");

        // retired wrap, then reset abandoning MEM_WAIT
        apply(1, OP_LD, 0, 0, 0, 0, o(3'd6, 0, 0, 0, 0, 2'd3), 0, "wr_rst");
        apply(0, OP_LD, 0, 0, 0, 0, o(3'd0, 0, 0, 0, 0, 2'd0), 0, "wr_reset");
        apply(0, OP_LD, 1, 0, 0, 0, o(3'd1, 1, 1, 0, 0, 2'd0), 0, "wr_fetch");
        apply(0, OP_LD, 0, 0, 0, 0, o(3'd2, 0, 0, 0, 0, 2'd0), 0, "wr_decode");
        apply(0, OP_LD, 0, 0, 0, 0, o(3'd3, 0, 0, 0, 0, 2'd0), 0, "wr_exec");
        apply(0, OP_LD, 0, 1, 0, 0, o(3'd4, 0, 0, 0, 1, 2'd0), 0, "wr_memreq");
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        apply(0, OP_LD, 0, 0, 1, 0, o(3'd5, 0, 0, 1, 0, 2'd0), 32'hFFFF_FFFF, "wr_retire");
        apply(0, OP_LD, 1, 0, 0, 0, o(3'd1, 1, 1, 0, 0, 2'd0), 0, "wr_wrapped");
        apply(0, OP_LD, 0, 0, 0, 0, o(3'd2, 0, 0, 0, 0, 2'd0), 0, "rm_decode");
        apply(0, OP_LD, 0, 0, 0, 0, o(3'd3, 0, 0, 0, 0, 2'd0), 0, "rm_exec");
        apply(0, OP_LD, 0, 1, 0, 0, o(3'd4, 0, 0, 0, 1, 2'd0), 0, "rm_memreq");
        force dut.retired_q = 32'h1234_5678;
        #1;
        release dut.retired_q;
        apply(1, OP_LD, 0, 0, 0, 0, o(3'd5, 0, 0, 0, 0, 2'd0), 32'h1234_5678, "rm_rst");
        apply(0, OP_LD, 0, 0, 0, 0, o(3'd0, 0, 0, 0, 0, 2'd0), 0, "rm_reset");
        apply(0, OP_LD, 1, 0, 0, 0, o(3'd1, 1, 1, 0, 0, 2'd0), 0, "rm_fetch");

        // randomized run against the phase model, starting from a reset
        apply(1, OP_LD, 0, 0, 0, 0, o(3'd2, 0, 0, 0, 0, 2'd0), 0, "rnd_rst");
        m_ph = M_RESET; m_err = 2'd0; m_ret = 0; m_dwell = 0;
        for (int n = 0; n < 3000; n++) begin
            r_r  = (m_ph == M_HALT) ? ($urandom_range(7) == 0) : ($urandom_range(199) == 0);
            r_op = ($urandom_range(9) < 8) ? legal_ops[$urandom_range(8)] : 7'($urandom);
            r_iv = 1'($urandom_range(1));
            r_lr = ($urandom_range(9) < 6);
            r_lv = ($urandom_range(9) < 4);
            r_hi = ($urandom_range(29) == 0);
            model_step(r_r, r_op, r_iv, r_lr, r_lv, r_hi, r_eo, r_er);
            apply(r_r, r_op, r_iv, r_lr, r_lv, r_hi, r_eo, r_er, $sformatf("rnd[%0d]", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
